texture_fill_ctrl: RTL and testbench
====================================

Name: texture_fill_ctrl

Overview:
- Sits directly upstream of texture_cache and is its only client.
- Takes texel-line requests, probes the cache, and returns hit data.
- On a miss it issues one memory read and assembles the two-beat response into a 296-bit line.
- It then writes the line into the cache and returns it to the requester; `except` aborts the miss and drains any orphan memory response.

Parameters:
- ADDR_W, 39, line address width (44-bit physical address, 32-byte lines).
- LINE_W, 296, cached line payload width.
- BEAT_W, 148, memory response beat width (LINE_W/2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- except  in  1  pipeline flush; kills the in-flight request.
- req_en  in  1  request valid.
- req_addr  in  ADDR_W  requested line address.
- req_ready  out  1  controller can accept a request this cycle.
- resp_en  out  1  response valid, one-cycle pulse.
- resp_data  out  LINE_W  returned line.
- tc_read_clkEn  out  1  cache probe enable.
- tc_read_addr  out  ADDR_W  cache probe address.
- tc_read_data  in  LINE_W  cache data, combinational.
- tc_read_hit  in  1  cache hit, combinational.
- tc_write_addr  out  ADDR_W  fill address.
- tc_write_data  out  LINE_W  fill line.
- tc_write_wen  out  1  fill write strobe.
- mem_req_en  out  1  memory read request, held until acked.
- mem_req_addr  out  ADDR_W  memory request address.
- mem_req_ack  in  1  memory accepted the request.
- mem_rsp_en  in  1  response beat valid.
- mem_rsp_data  in  BEAT_W  response beat; the first beat is the low half.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - Reset: state=IDLE; req_ready=0 in the reset cycle and 1 from the next cycle.
  - Reset: resp_en=0, resp_data=0, mem_req_en=0, tc_write_wen=0, beat counter=0.
- States: IDLE, MREQ, MWAIT, FILL, DRAIN.
- IDLE:
  - req_ready=1.
  - tc_read_clkEn=req_en and tc_read_addr=req_addr, combinationally in the same cycle.
  - If req_en and tc_read_hit: register tc_read_data into resp_data and pulse resp_en the next cycle (latency 1); stay in IDLE, so back-to-back hits give 1/cycle.
  - If req_en and miss: latch the address into addr_q and go to MREQ.
- MREQ:
  - mem_req_en=1, mem_req_addr=addr_q.
  - On mem_req_ack go to MWAIT with beat counter=0.
- MWAIT:
  - Each mem_rsp_en stores a beat: beat 0 goes to line_q[147:0], beat 1 to line_q[295:148].
  - After beat 1 go to FILL.
- FILL (1 cycle):
  - tc_write_wen=1, tc_write_addr=addr_q, tc_write_data=line_q.
  - Next cycle: resp_en=1 with resp_data=line_q; state returns to IDLE.
  - Miss latency from ack to resp_en: (beats arrival)+2.
- req_ready=0 in every state except IDLE; a request presented while not ready is ignored, and the requester must hold it.
- except:
  - In IDLE: same-cycle hit response suppressed (no resp_en next cycle).
  - In MREQ: go to IDLE if not yet acked. If acked that same cycle, go to DRAIN.
  - In MWAIT: go to DRAIN, keeping the beat counter.
  - In FILL: the cache write is suppressed (tc_write_wen forced 0) and resp_en is not raised.
  - except never cancels a memory request already acked; the controller must consume both beats.
- DRAIN: count the remaining beats, discarding the data. After the second beat go to IDLE with req_ready=1. Further except pulses in DRAIN are ignored.
- Simultaneous events:
  - except and the last beat in the same cycle: the beat counts as drained; go to IDLE.
  - mem_rsp_en in IDLE or MREQ is a protocol error; ignore it, with an assertion in simulation.
- Boundary cases:
  - Repeated miss to the same index after a fill overwrites the way (direct-mapped, index=addr[1:0]); no victim handling is needed.
  - rst mid-miss returns to IDLE without drain; memory is reset together with this block.

Decomposition:
- Shared package tex_pkg:
  - Constants: ADDR_W, LINE_W, BEAT_W.
  - FSM state enum: IDLE=0, MREQ=1, MWAIT=2, FILL=3, DRAIN=4.
  - Typedef for the line payload.
- One natural sub-module: tex_beat_assembler (beat counter plus the two-half line register, with clear and drain modes).

Test Plan:
- Hit:
  - Stimulus: cache model preloaded at index 2 with addr 0x1234566; req_en with that address in IDLE.
  - Required: resp_en 1 cycle later with the preloaded data; no mem_req_en.
- Miss:
  - Stimulus: req 0x00ABC01; ack after 3 cycles; beats 0x1..1 then 0x2..2 on consecutive cycles.
  - Required: tc_write_wen one cycle after beat 1 with line {beat1,beat0}; resp_en the next cycle; a re-request then hits.
- Back-to-back hits:
  - Stimulus: 4 hits to indices 0–3 on consecutive cycles.
  - Required: 4 consecutive resp_en pulses in order; req_ready stays 1.
- Flush during miss:
  - Stimulus: except in MWAIT after beat 0.
  - Required: no cache write, no resp_en; req_ready returns to 1 only after beat 1 arrives.
- Flush before ack:
  - Stimulus: except in MREQ with ack=0.
  - Required: IDLE next cycle; mem_req_en drops; no drain.
- Reset mid-miss:
  - Stimulus: rst in MWAIT.
  - Required: all outputs at reset values next cycle; req_ready=1 the cycle after.

Source files
------------

// File: rtl/tex_pkg.sv
// Shared definitions for the texture fill controller.
//   ADDR_W  line address width (44-bit physical address, 32-byte lines)
//   LINE_W  cached line payload width
//   BEAT_W  memory response beat width; a line arrives as two beats
//   fill_state_e  controller state encoding
//   line_t        one cache line payload
package tex_pkg;

    localparam int ADDR_W = 39;
    localparam int LINE_W = 296;
    localparam int BEAT_W = LINE_W / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MREQ  = 3'd1,
        MWAIT = 3'd2,
        FILL  = 3'd3,
        DRAIN = 3'd4
    } fill_state_e;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/texture_fill_ctrl_if.sv
// Bus bundle between the fill controller and its environment.
//   requester : except, req_en, req_addr, req_ready, resp_en, resp_data
//   cache     : tc_read_clkEn, tc_read_addr, tc_read_data, tc_read_hit,
//               tc_write_addr, tc_write_data, tc_write_wen
//   memory    : mem_req_en, mem_req_addr, mem_req_ack, mem_rsp_en, mem_rsp_data
// master = controller side, slave = environment side.
interface texture_fill_ctrl_if;
    import tex_pkg::*;

    logic                 except;
    logic                 req_en;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_ready;
    logic                 resp_en;
    line_t                resp_data;

    logic                 tc_read_clkEn;
    logic [ADDR_W-1:0]    tc_read_addr;
    line_t                tc_read_data;
    logic                 tc_read_hit;
    logic [ADDR_W-1:0]    tc_write_addr;
    line_t                tc_write_data;
    logic                 tc_write_wen;

    logic                 mem_req_en;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic                 mem_req_ack;
    logic                 mem_rsp_en;
    logic [BEAT_W-1:0]    mem_rsp_data;

    modport master (
        input  except, req_en, req_addr, tc_read_data, tc_read_hit,
               mem_req_ack, mem_rsp_en, mem_rsp_data,
        output req_ready, resp_en, resp_data, tc_read_clkEn, tc_read_addr,
               tc_write_addr, tc_write_data, tc_write_wen, mem_req_en, mem_req_addr
    );

    modport slave (
        output except, req_en, req_addr, tc_read_data, tc_read_hit,
               mem_req_ack, mem_rsp_en, mem_rsp_data,
        input  req_ready, resp_en, resp_data, tc_read_clkEn, tc_read_addr,
               tc_write_addr, tc_write_data, tc_write_wen, mem_req_en, mem_req_addr
    );

endinterface

// File: rtl/tex_beat_assembler.sv
// Collects the two memory response beats of a line.
//   clk, rst   clock and synchronous active-high reset
//   clear      restart at beat 0 (issued when memory accepts a request)
//   beat_en    a response beat is present this cycle
//   store      keep the beat data (0 = drain mode: count only)
//   beat_data  beat payload; beat 0 is the low half of the line
//   line       assembled line {beat1, beat0}
//   last_beat  the beat presented this cycle completes the line
module tex_beat_assembler
    import tex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_en,
    input  logic              store,
    input  logic [BEAT_W-1:0] beat_data,
    output line_t             line,
    output logic              last_beat
);

    logic beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = 1'b0;
        end else if (beat_en) begin
            beat_cnt_d = ~beat_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign last_beat = beat_en & beat_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            localparam bit HALF_SEL = (gi == 1);
            logic [BEAT_W-1:0] half_q, half_d;

            always_comb begin
                half_d = half_q;
                if (beat_en && store && (beat_cnt_q == HALF_SEL)) begin
                    half_d = beat_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    half_q <= '0;
                end else begin
                    half_q <= half_d;
                end
            end
        end
    endgenerate

    assign line = {g_half[1].half_q, g_half[0].half_q};

endmodule

// File: rtl/texture_fill_ctrl.sv
// Texture line fill controller, sole client of texture_cache.
//   clk, rst  clock and synchronous active-high reset
//   bus       requester, cache-probe/fill and memory-read signals
// Hits return the probed line one cycle after the request. A miss issues a
// single memory read, assembles two beats, writes the cache, then responds.
// except kills the in-flight request; an already-acked read is drained.
module texture_fill_ctrl
    import tex_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    texture_fill_ctrl_if.master bus
);

    fill_state_e       state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_en_q, resp_en_d;
    line_t             resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_en_q, mem_req_en_d;

    logic              asm_clear, asm_beat_en, asm_store, asm_last;
    line_t             asm_line;
    logic              accept;

    // req_ready is registered, so it is low for the cycle after reset even
    // though the state is already IDLE; requests are only taken when high.
    assign accept = req_ready_q & bus.req_en;

    tex_beat_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .beat_en   (asm_beat_en),
        .store     (asm_store),
        .beat_data (bus.mem_rsp_data),
        .line      (asm_line),
        .last_beat (asm_last)
    );

    always_comb begin
        state_d     = state_q;
        resp_en_d   = 1'b0;
        resp_data_d = resp_data_q;
        addr_d      = addr_q;
        asm_clear   = 1'b0;
        asm_beat_en = 1'b0;
        asm_store   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && !bus.except) begin
                    if (bus.tc_read_hit) begin
                        resp_en_d   = 1'b1;
                        resp_data_d = bus.tc_read_data;
                    end else begin
                        addr_d  = bus.req_addr;
                        state_d = MREQ;
                    end
                end
            end
            MREQ: begin
                // An ack in the flush cycle still commits memory to two beats.
                if (bus.mem_req_ack) begin
                    asm_clear = 1'b1;
                    state_d   = bus.except ? DRAIN : MWAIT;
                end else if (bus.except) begin
                    state_d = IDLE;
                end
            end
            MWAIT: begin
                asm_beat_en = bus.mem_rsp_en;
                asm_store   = 1'b1;
                if (bus.except) begin
                    state_d = asm_last ? IDLE : DRAIN;
                end else if (asm_last) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
                if (!bus.except) begin
                    resp_en_d   = 1'b1;
                    resp_data_d = asm_line;
                end
            end
            DRAIN: begin
                asm_beat_en = bus.mem_rsp_en;
                if (asm_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        mem_req_en_d = (state_d == MREQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_en_q    <= 1'b0;
            resp_data_q  <= '0;
            addr_q       <= '0;
            mem_req_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_en_q    <= resp_en_d;
            resp_data_q  <= resp_data_d;
            addr_q       <= addr_d;
            mem_req_en_q <= mem_req_en_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_en       = resp_en_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.tc_read_clkEn = accept;
    assign bus.tc_read_addr  = bus.req_addr;
    assign bus.tc_write_addr = addr_q;
    assign bus.tc_write_data = asm_line;
    assign bus.tc_write_wen  = (state_q == FILL) && !bus.except;
    assign bus.mem_req_en    = mem_req_en_q;
    assign bus.mem_req_addr  = addr_q;

    // Beats are only legal once memory has accepted a request.
    mem_rsp_in_window: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_en |-> !(state_q == IDLE || state_q == MREQ));

endmodule

// File: tb/tb_texture_fill_ctrl.sv
module tb_texture_fill_ctrl;
    import tex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    texture_fill_ctrl_if bus();

    texture_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard queues ----------------
    typedef struct { line_t data; int due; } resp_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; line_t data; } wr_exp_t;
    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    // ---------------- reference model: set of resident lines ----------------
    line_t ref_line [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] last_miss_addr = '0;

    function automatic void ref_fill(input logic [ADDR_W-1:0] a, input line_t d);
        logic [ADDR_W-1:0] victims[$];
        foreach (ref_line[k]) if (k[1:0] == a[1:0]) victims.push_back(k);
        foreach (victims[i]) ref_line.delete(victims[i]);
        ref_line[a] = d;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(input logic [ADDR_W-1:0] a, input int k);
        logic [ADDR_W-1:0] m;
        m = {13{3'b101}};
        return {a, ~a, a ^ m, (k == 0) ? 31'h0BEEF002 : 31'h7ACE0001};
    endfunction

    function automatic line_t mem_line(input logic [ADDR_W-1:0] a);
        return {beat_of(a, 1), beat_of(a, 0)};
    endfunction

    // ---------------- environment cache (4-entry direct-mapped) ----------------
    bit                env_valid [4];
    logic [ADDR_W-1:0] env_tag   [4];
    line_t             env_data  [4];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    line_t             pl_data = '0;

    assign bus.tc_read_hit  = bus.tc_read_clkEn && env_valid[bus.tc_read_addr[1:0]]
                              && (env_tag[bus.tc_read_addr[1:0]] == bus.tc_read_addr);
    assign bus.tc_read_data = env_data[bus.tc_read_addr[1:0]];

    always @(posedge clk) begin
        if (bus.tc_write_wen) begin
            env_valid[bus.tc_write_addr[1:0]] <= 1'b1;
            env_tag[bus.tc_write_addr[1:0]]   <= bus.tc_write_addr;
            env_data[bus.tc_write_addr[1:0]]  <= bus.tc_write_data;
        end else if (pl_en) begin
            env_valid[pl_addr[1:0]] <= 1'b1;
            env_tag[pl_addr[1:0]]   <= pl_addr;
            env_data[pl_addr[1:0]]  <= pl_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input line_t got, input line_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input line_t d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_fill(a, d);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present one request; expectations are queued at acceptance.
    task automatic issue(input logic [ADDR_W-1:0] a, input line_t miss_line, input bit abort);
        int w;
        w = 0;
        while (!bus.req_ready && w < 500) begin @(negedge clk); w++; end
        chk("req_ready_wait", LINE_W'(bus.req_ready), LINE_W'(1'b1));
        bus.req_en = 1'b1;
        bus.req_addr = a;
        #1;
        chk("probe_enable", LINE_W'(bus.tc_read_clkEn), LINE_W'(1'b1));
        chk("probe_addr", LINE_W'(bus.tc_read_addr), LINE_W'(a));
        if (ref_line.exists(a)) begin
            if (!abort) resp_q.push_back('{ref_line[a], cyc + 1});
        end else begin
            last_miss_addr = a;
            if (!abort) begin
                wr_q.push_back('{a, miss_line});
                resp_q.push_back('{miss_line, -1});
                ref_fill(a, miss_line);
            end
        end
        @(negedge clk);
        bus.req_en = 1'b0;
    endtask

    // ---------------- monitor ----------------
    resp_exp_t re;
    wr_exp_t   we;
    always @(negedge clk) begin
        if (bus.resp_en) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got resp_en=1 data=%0h required no response", bus.resp_data);
            end else begin
                re = resp_q.pop_front();
                if (bus.resp_data !== re.data || (re.due >= 0 && re.due != cyc)) begin
                    errors++;
                    $display("FAIL resp_data: got %0h at cycle %0d required %0h at cycle %0d",
                             bus.resp_data, cyc, re.data, re.due);
                end else begin
                    $display("resp  cyc=%0d data[31:0]=%h", cyc, bus.resp_data[31:0]);
                end
            end
        end
        if (bus.tc_write_wen) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wen=1 addr=%0h required no write", bus.tc_write_addr);
            end else begin
                we = wr_q.pop_front();
                if (bus.tc_write_addr !== we.addr || bus.tc_write_data !== we.data) begin
                    errors++;
                    $display("FAIL cache_write: got addr=%0h data=%0h required addr=%0h data=%0h",
                             bus.tc_write_addr, bus.tc_write_data, we.addr, we.data);
                end else begin
                    $display("fill  cyc=%0d addr=%h", cyc, bus.tc_write_addr);
                end
            end
        end
    end

    // Memory responder used during the random phase.
    bit stim_done = 1'b0;
    task automatic mem_serve();
        logic [ADDR_W-1:0] ma;
        ma = bus.mem_req_addr;
        chk("mem_req_addr", LINE_W'(ma), LINE_W'(last_miss_addr));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.mem_req_ack = 1'b1;
        @(negedge clk);
        bus.mem_req_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.mem_rsp_en   = 1'b1;
            bus.mem_rsp_data = beat_of(ma, k);
            @(negedge clk);
            bus.mem_rsp_en = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    logic [BEAT_W-1:0] b0, b1;
    logic [ADDR_W-1:0] pool [6];
    logic [ADDR_W-1:0] a;
    int w;

    initial begin
        bus.except = 1'b0; bus.req_en = 1'b0; bus.req_addr = '0;
        bus.mem_req_ack = 1'b0; bus.mem_rsp_en = 1'b0; bus.mem_rsp_data = '0;
        b0 = {37{4'h1}};
        b1 = {37{4'h2}};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  LINE_W'(bus.req_ready),    '0);
        chk("rst_resp_en",    LINE_W'(bus.resp_en),      '0);
        chk("rst_resp_data",  bus.resp_data,             '0);
        chk("rst_mem_req_en", LINE_W'(bus.mem_req_en),   '0);
        chk("rst_write_wen",  LINE_W'(bus.tc_write_wen), '0);
        rst = 1'b0;
        chk("post_rst_ready_low", LINE_W'(bus.req_ready), '0);
        @(negedge clk);
        chk("post_rst_ready_high", LINE_W'(bus.req_ready), LINE_W'(1'b1));

        // Hit with 1-cycle latency, no memory traffic
        preload(39'h1234566, mem_line(39'h1234566) ^ {LINE_W{1'b1}});
        issue(39'h1234566, '0, 1'b0);
        chk("hit_no_mem_req", LINE_W'(bus.mem_req_en), '0);
        @(negedge clk);
        chk("hit_no_mem_req2", LINE_W'(bus.mem_req_en), '0);

        // except on a hit suppresses the response
        bus.except = 1'b1;
        issue(39'h1234566, '0, 1'b1);
        bus.except = 1'b0;
        chk("flush_hit_no_resp", LINE_W'(bus.resp_en), '0);

        // Miss: ack after 3 cycles, beats back to back
        issue(39'h00ABC01, {b1, b0}, 1'b0);
        chk("miss_mem_req_en", LINE_W'(bus.mem_req_en), LINE_W'(1'b1));
        chk("miss_mem_req_addr", LINE_W'(bus.mem_req_addr), LINE_W'(39'h00ABC01));
        chk("miss_not_ready", LINE_W'(bus.req_ready), '0);
        repeat (2) @(negedge clk);
        chk("miss_req_held", LINE_W'(bus.mem_req_en), LINE_W'(1'b1));
        bus.mem_req_ack = 1'b1;
        @(negedge clk);
        bus.mem_req_ack = 1'b0;
        bus.mem_rsp_en = 1'b1; bus.mem_rsp_data = b0;
        @(negedge clk);
        chk("miss_req_dropped", LINE_W'(bus.mem_req_en), '0);
        bus.mem_rsp_data = b1;
        @(negedge clk);
        bus.mem_rsp_en = 1'b0;
        chk("miss_fill_wen", LINE_W'(bus.tc_write_wen), LINE_W'(1'b1));
        @(negedge clk);
        chk("miss_resp_en", LINE_W'(bus.resp_en), LINE_W'(1'b1));
        issue(39'h00ABC01, '0, 1'b0);
        chk("rehit_no_mem_req", LINE_W'(bus.mem_req_en), '0);

        // Back-to-back hits to indices 0..3
        for (int i = 0; i < 4; i++) preload(39'h0300100 + 39'(i), mem_line(39'h0300100 + 39'(i)));
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", LINE_W'(bus.req_ready), LINE_W'(1'b1));
            issue(39'h0300100 + 39'(i), '0, 1'b0);
        end
        @(negedge clk);

        // except in MWAIT after beat 0: drain, no write, no response
        issue(39'h0555502, '0, 1'b1);
        bus.mem_req_ack = 1'b1;
        @(negedge clk);
        bus.mem_req_ack = 1'b0;
        bus.mem_rsp_en = 1'b1; bus.mem_rsp_data = b0;
        @(negedge clk);
        bus.mem_rsp_en = 1'b0;
        bus.except = 1'b1;
        @(negedge clk);
        bus.except = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_not_ready", LINE_W'(bus.req_ready), '0);
            @(negedge clk);
        end
        bus.mem_rsp_en = 1'b1; bus.mem_rsp_data = b1;
        @(negedge clk);
        bus.mem_rsp_en = 1'b0;
        chk("drain_done_ready", LINE_W'(bus.req_ready), LINE_W'(1'b1));
        chk("drain_no_write", LINE_W'(bus.tc_write_wen), '0);
        @(negedge clk);
        chk("drain_no_resp", LINE_W'(bus.resp_en), '0);

        // except together with the last beat: counted as drained
        issue(39'h0555503, '0, 1'b1);
        bus.mem_req_ack = 1'b1;
        @(negedge clk);
        bus.mem_req_ack = 1'b0;
        bus.mem_rsp_en = 1'b1; bus.mem_rsp_data = b0;
        @(negedge clk);
        bus.mem_rsp_data = b1; bus.except = 1'b1;
        @(negedge clk);
        bus.mem_rsp_en = 1'b0; bus.except = 1'b0;
        chk("flush_last_ready", LINE_W'(bus.req_ready), LINE_W'(1'b1));
        chk("flush_last_no_write", LINE_W'(bus.tc_write_wen), '0);
        @(negedge clk);
        chk("flush_last_no_resp", LINE_W'(bus.resp_en), '0);

        // except in MREQ before ack
        issue(39'h0555500, '0, 1'b1);
        chk("mreq_req_en", LINE_W'(bus.mem_req_en), LINE_W'(1'b1));
        bus.except = 1'b1;
        @(negedge clk);
        bus.except = 1'b0;
        chk("mreq_flush_req_drop", LINE_W'(bus.mem_req_en), '0);
        chk("mreq_flush_ready", LINE_W'(bus.req_ready), LINE_W'(1'b1));

        // Reset in MWAIT
        issue(39'h0555501, '0, 1'b1);
        bus.mem_req_ack = 1'b1;
        @(negedge clk);
        bus.mem_req_ack = 1'b0;
        bus.mem_rsp_en = 1'b1; bus.mem_rsp_data = b0;
        @(negedge clk);
        bus.mem_rsp_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_ready",  LINE_W'(bus.req_ready),    '0);
        chk("midrst_resp_en",    LINE_W'(bus.resp_en),      '0);
        chk("midrst_resp_data",  bus.resp_data,             '0);
        chk("midrst_mem_req_en", LINE_W'(bus.mem_req_en),   '0);
        chk("midrst_write_wen",  LINE_W'(bus.tc_write_wen), '0);
        @(negedge clk);
        chk("midrst_ready_back", LINE_W'(bus.req_ready), LINE_W'(1'b1));

        // Random traffic over a small address pool
        for (int i = 0; i < 6; i++) pool[i] = 39'($urandom) ^ {$urandom_range(0, 7), 36'h0};
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    a = pool[$urandom_range(0, 5)];
                    issue(a, mem_line(a), 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                w = 0;
                while ((resp_q.size() != 0 || wr_q.size() != 0) && w < 2000) begin
                    @(negedge clk); w++;
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    if (bus.mem_req_en && !stim_done) mem_serve();
                end
            end
        join

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", LINE_W'(resp_q.size()), '0);
        chk("write_queue_empty", LINE_W'(wr_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
